prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 93 +++++++++
 tb/tb_prog_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: parses a framed byte stream, writes payloads to RAM, and releases the CPU on a run header.
// Frame: HDR_WRITE, ADDR_HI, ADDR_LO, LEN (0 => 256), payload, CSUM; the 8-bit sum of all but the header must be zero.
module prog_loader #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] HDR_WRITE  = 8'hA5,
    parameter logic [DATA_WIDTH-1:0] HDR_RUN    = 8'h5A
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  frame_ok,
    output logic                  csum_err
);
    typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, LEN, DATA, CSUM, RUN} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH:0]   cnt_q;
    logic [7:0]            csum_q;
    logic [7:0]            csum_d;
    logic [DATA_WIDTH:0]   len_d;

    assign csum_d = csum_q + rx_data[7:0];
    // A zero length field stands for the full 2^DATA_WIDTH byte payload.
    assign len_d  = (rx_data == '0) ? {1'b1, {DATA_WIDTH{1'b0}}} : {1'b0, rx_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            csum_q    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            frame_ok  <= 1'b0;
            csum_err  <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            frame_ok <= 1'b0;
            if (rx_valid) begin
                case (state_q)
                    IDLE: begin
                        if (rx_data == HDR_WRITE) begin
                            state_q <= ADDR_HI;
                        end else if (rx_data == HDR_RUN) begin
                            state_q  <= RUN;
                            cpu_hold <= 1'b0;
                        end
                    end
                    ADDR_HI: begin
                        addr_q  <= ADDR_WIDTH'(rx_data);
                        csum_q  <= rx_data[7:0];
                        state_q <= ADDR_LO;
                    end
                    ADDR_LO: begin
                        addr_q  <= (addr_q << DATA_WIDTH) | ADDR_WIDTH'(rx_data);
                        csum_q  <= csum_d;
                        state_q <= LEN;
                    end
                    LEN: begin
                        cnt_q   <= len_d;
                        csum_q  <= csum_d;
                        state_q <= DATA;
                    end
                    DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_q;
                        mem_wdata <= rx_data;
                        addr_q    <= addr_q + 1'b1;
                        cnt_q     <= cnt_q - 1'b1;
                        csum_q    <= csum_d;
                        state_q   <= (cnt_q == (DATA_WIDTH+1)'(1)) ? CSUM : DATA;
                    end
                    CSUM: begin
                        frame_ok <= (csum_d == 8'h00);
                        csum_err <= csum_err | (csum_d != 8'h00);
                        state_q  <= IDLE;
                    end
                    RUN:     state_q <= RUN;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed vector table, timing sequences and random frames checked against a frame-level model.
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        frame_ok;
    logic        csum_err;

    prog_loader dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .frame_ok(frame_ok), .csum_err(csum_err)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          fok_cnt = 0;
    logic [23:0] got_q[$];
    logic [23:0] exp_q[$];

    always @(negedge clk) begin
        if (mem_we) got_q.push_back({mem_addr, mem_wdata});
        if (frame_ok) fok_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        got_q.delete();
        fok_cnt = 0;
    endtask

    typedef struct packed {
        logic [0:9][7:0] b;
        int              n;
        int              nw;
        logic [23:0]     w0;
        logic [23:0]     w1;
        int              ok;
        logic            err;
        logic            hold;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0]  sum;
        logic [7:0]  csum;
        logic [7:0]  junk;
        logic [15:0] addr;
        logic [7:0]  pay[$];
        int          len;
        int          exp_ok;
        int          errs;
        logic        exp_err;
        logic        bad;

        vecs[0] = '{{8'hA5,8'hF0,8'h00,8'h02,8'h3E,8'h33,8'h9D,8'h00,8'h00,8'h00}, 7, 2, 24'hF0003E, 24'hF00133, 1, 1'b0, 1'b1};
        vecs[1] = '{{8'hA5,8'hF0,8'h00,8'h02,8'h3E,8'h33,8'h00,8'h00,8'h00,8'h00}, 7, 2, 24'hF0003E, 24'hF00133, 0, 1'b1, 1'b1};
        vecs[2] = '{{8'hA5,8'hFF,8'hFF,8'h02,8'h11,8'h22,8'hCD,8'h00,8'h00,8'h00}, 7, 2, 24'hFFFF11, 24'h000022, 1, 1'b0, 1'b1};
        vecs[3] = '{{8'h00,8'h33,8'h5A,8'hA5,8'hF0,8'h00,8'h01,8'h44,8'hCB,8'h00}, 9, 0, 24'h0, 24'h0, 0, 1'b0, 1'b0};
        vecs[4] = '{{8'hA5,8'h12,8'h34,8'h01,8'h56,8'h63,8'h00,8'h00,8'h00,8'h00}, 6, 1, 24'h123456, 24'h123456, 1, 1'b0, 1'b1};
        vecs[5] = '{{8'h00,8'hFF,8'hA5,8'h00,8'h10,8'h01,8'hAB,8'h44,8'h00,8'h00}, 8, 1, 24'h0010AB, 24'h0010AB, 1, 1'b0, 1'b1};

        @(negedge clk);
        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int i = 0; i < vecs[v].n; i++) put(vecs[v].b[i]);
            idle(3);
            chk($sformatf("v%0d_writes", v), got_q.size(), vecs[v].nw);
            if (vecs[v].nw > 0) chk($sformatf("v%0d_first", v), got_q[0], vecs[v].w0);
            if (vecs[v].nw > 1) chk($sformatf("v%0d_last", v), got_q[got_q.size()-1], vecs[v].w1);
            chk($sformatf("v%0d_frame_ok", v), fok_cnt, vecs[v].ok);
            chk($sformatf("v%0d_csum_err", v), csum_err, vecs[v].err);
            chk($sformatf("v%0d_cpu_hold", v), cpu_hold, vecs[v].hold);
        end

        // reset values and cycle-exact write / pulse timing
        do_reset();
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_ok", frame_ok, 0);
        chk("rst_err", csum_err, 0);
        put(8'hA5); put(8'hF0); put(8'h00); put(8'h02);
        chk("t_no_we_hdr", mem_we, 0);
        put(8'h3E);
        chk("t_we0", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'hF000, 8'h3E});
        put(8'h33);
        chk("t_we1", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'hF001, 8'h33});
        put(8'h9D);
        chk("t_csum_no_we", mem_we, 0);
        chk("t_ok_pulse", frame_ok, 1);
        idle(1);
        chk("t_ok_one_cycle", frame_ok, 0);
        chk("t_hold_vals", {mem_addr, mem_wdata}, {16'hF001, 8'h33});

        // sticky error, later good frame still pulses
        put(8'hA5); put(8'h01); put(8'h02); put(8'h01); put(8'h03); put(8'h01);
        chk("e_err_set", csum_err, 1);
        chk("e_no_ok", frame_ok, 0);
        idle(2);
        put(8'hA5); put(8'h12); put(8'h34); put(8'h01); put(8'h56); put(8'h63);
        chk("e_ok_after_err", frame_ok, 1);
        chk("e_err_sticky", csum_err, 1);

        // reset wins over a simultaneous header byte
        reset = 1'b1; rx_data = 8'hA5; rx_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0; rx_valid = 1'b0;
        got_q.delete(); fok_cnt = 0;
        chk("r_hold_before_run", cpu_hold, 1);
        put(8'h5A);
        chk("r_hold_after_run", cpu_hold, 0);
        put(8'hA5); put(8'hF0); put(8'h00); put(8'h01); put(8'h44); put(8'hCB);
        idle(2);
        chk("r_run_no_writes", got_q.size(), 0);
        chk("r_run_no_ok", fok_cnt, 0);

        // reset mid-frame abandons it
        do_reset();
        put(8'hA5); put(8'hF0);
        do_reset();
        put(8'h00); put(8'h01); put(8'h77);
        idle(2);
        chk("m_no_writes", got_q.size(), 0);
        chk("m_hold", cpu_hold, 1);
        put(8'hA5); put(8'h12); put(8'h34); put(8'h01); put(8'h56); put(8'h63);
        idle(1);
        chk("m_idle_then_frame", got_q.size(), 1);

        // 256-byte frame via LEN=0
        do_reset();
        put(8'hA5); put(8'h00); put(8'h00); put(8'h00);
        for (int i = 0; i < 256; i++) put(8'(i));
        put(8'h80);
        idle(2);
        chk("b_writes", got_q.size(), 256);
        errs = 0;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== {16'(i), 8'(i)}) errs++;
        chk("b_data", errs, 0);
        chk("b_ok", fok_cnt, 1);

        // random frames against a frame-level model
        do_reset();
        exp_ok = 0;
        exp_err = 1'b0;
        for (int f = 0; f < 30; f++) begin
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                junk = 8'($urandom);
                if (junk == 8'hA5 || junk == 8'h5A) junk = 8'h00;
                put(junk);
            end
            len = ($urandom_range(0, 15) == 0) ? 256 : $urandom_range(1, 8);
            addr = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
            pay.delete();
            sum = addr[15:8] + addr[7:0] + 8'(len);
            for (int i = 0; i < len; i++) begin
                pay.push_back(8'($urandom));
                sum += pay[i];
                exp_q.push_back({addr + 16'(i), pay[i]});
            end
            bad = ($urandom_range(0, 3) == 0);
            csum = bad ? 8'(-sum + 8'($urandom_range(1, 255))) : 8'(-sum);
            if (bad) exp_err = 1'b1; else exp_ok++;
            put(8'hA5);
            idle($urandom_range(0, 1));
            put(addr[15:8]);
            put(addr[7:0]);
            idle($urandom_range(0, 1));
            put(8'(len));
            for (int i = 0; i < len; i++) begin
                idle($urandom_range(0, 1));
                put(pay[i]);
            end
            idle($urandom_range(0, 2));
            put(csum);
            idle(2);
            chk($sformatf("rnd%0d_writes", f), got_q.size(), exp_q.size());
            errs = 0;
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) errs++;
            chk($sformatf("rnd%0d_data", f), errs, 0);
            chk($sformatf("rnd%0d_ok", f), fok_cnt, exp_ok);
            chk($sformatf("rnd%0d_err", f), csum_err, exp_err);
            got_q.delete();
            exp_q.delete();
        end
        put(8'h5A);
        chk("rnd_run_hold", cpu_hold, 0);
        for (int i = 0; i < 12; i++) put(8'($urandom));
        idle(2);
        chk("rnd_run_no_writes", got_q.size(), 0);
        chk("rnd_run_ok_unchanged", fok_cnt, exp_ok);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
